down_timer: RTL and testbench



---
 rtl/counter_pkg.sv | 13 +
 rtl/down_timer_if.sv | 25 ++
 rtl/down_timer_prescaler.sv | 25 ++
 rtl/down_timer.sv | 80 ++++++++
 tb/tb_down_timer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared counter/timer package: FSM state encoding and default widths.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int STATE_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer; master drives control, slave is the timer.
interface down_timer_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] count_out;
    logic             tc_pulse;
    logic             zero;
    logic             busy;

    modport master (
        output enable, load, load_value, auto_reload,
        input  count_out, tc_pulse, zero, busy
    );

    modport slave (
        input  enable, load, load_value, auto_reload,
        output count_out, tc_pulse, zero, busy
    );
endinterface

// File: rtl/down_timer_prescaler.sv
// Tick generator: one tick every PRESCALE enabled clocks, synchronous clear.
module down_timer_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/down_timer.sv
// Loadable down counter / interval timer with one-shot and auto-reload modes.
// Optional prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic         clock,
    input  logic         reset,
    down_timer_if.slave  tif
);
    state_t           state, nxt_state;
    logic [WIDTH-1:0] count, nxt_count;
    logic [WIDTH-1:0] reload, nxt_reload;
    logic             tc, nxt_tc;
    logic             run_en;
    logic             tick;

    // A load edge never decrements, so it is masked out of the count qualifier.
    assign run_en = tif.enable && (state == RUN) && !tif.load;

`ifdef DOWN_TIMER_PRESCALE_EN
    down_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (tif.load || (state != RUN)),
        .enable (run_en),
        .tick   (tick)
    );
`else
    assign tick = run_en;
    if (PRESCALE < 1) begin : g_bad_prescale
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            state  <= nxt_state;
            count  <= nxt_count;
            reload <= nxt_reload;
            tc     <= nxt_tc;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_count  = count;
        nxt_reload = reload;
        nxt_tc     = 1'b0;
        if (tif.load) begin
            nxt_count  = tif.load_value;
            nxt_reload = tif.load_value;
            nxt_state  = (tif.load_value != '0) ? RUN : DONE;
        end else if (state == RUN && tick) begin
            // <= 1 rather than == 1 so a zero count can never underflow.
            if (count <= WIDTH'(1)) begin
                nxt_tc = 1'b1;
                if (tif.auto_reload) begin
                    nxt_count = reload;
                end else begin
                    nxt_count = '0;
                    nxt_state = DONE;
                end
            end else begin
                nxt_count = count - 1'b1;
            end
        end
    end

    assign tif.count_out = count;
    assign tif.tc_pulse  = tc;
    assign tif.zero      = (count == '0);
    assign tif.busy      = (state == RUN);
endmodule

// File: tb/tb_down_timer.sv
// Directed scoreboard bench for down_timer (default build; prescale sequence under DOWN_TIMER_PRESCALE_EN).
module tb_down_timer;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] count;
        logic         tc;
        logic         busy;
        logic         zero;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    down_timer_if #(.WIDTH(W)) tif ();

    down_timer #(.WIDTH(W), .PRESCALE(4)) dut (
        .clock (clock),
        .reset (reset),
        .tif   (tif)
    );

    always #5 clock = ~clock;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic push_exp(input logic [W-1:0] c, input logic t, input logic b, input string tag);
        obs_t e;
        e.count = c;
        e.tc    = t;
        e.busy  = b;
        e.zero  = (c == '0);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        obs_t  e, o;
        string tag;
        e = exp_q.pop_front();
        tag = tag_q.pop_front();
        o.count = tif.count_out;
        o.tc    = tif.tc_pulse;
        o.busy  = tif.busy;
        o.zero  = tif.zero;
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: got count=%0h tc=%b busy=%b zero=%b, want count=%0h tc=%b busy=%b zero=%b",
                   tag, o.count, o.tc, o.busy, o.zero, e.count, e.tc, e.busy, e.zero);
        end
    endtask

    // Drive at negedge, register the expectation, sample 1 ns after the rising edge.
    task automatic step(input logic en, input logic ld, input logic [W-1:0] lv, input logic ar,
                        input logic [W-1:0] c, input logic t, input logic b, input string tag);
        @(negedge clock);
        tif.enable      = en;
        tif.load        = ld;
        tif.load_value  = lv;
        tif.auto_reload = ar;
        push_exp(c, t, b, tag);
        @(posedge clock);
        #1;
        check();
    endtask

    initial begin
        tif.enable      = 1'b0;
        tif.load        = 1'b0;
        tif.load_value  = '0;
        tif.auto_reload = 1'b0;

        #2;
        push_exp(8'h00, 1'b0, 1'b0, "reset_init");
        check();
        @(negedge clock);
        reset = 1'b1;

`ifndef DOWN_TIMER_PRESCALE_EN
        // Idle: enable ignored without a load
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "idle_en1");
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "idle_en0");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "idle_en1b");

        // Async reset mid-count
        step(1'b0, 1'b1, 8'h20, 1'b0, 8'h20, 1'b0, 1'b1, "load_20");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h1F, 1'b0, 1'b1, "dec_1f");
        #2;
        reset = 1'b0;
        push_exp(8'h00, 1'b0, 1'b0, "reset_mid");
        #1;
        check();
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "post_reset_idle");
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "post_reset_idle2");

        // One-shot from 5; load wins over enable on the load edge
        step(1'b1, 1'b1, 8'h05, 1'b0, 8'h05, 1'b0, 1'b1, "os_load5");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, "os_4");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b1, "os_3");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, "os_2");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, "os_1");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "os_tc");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "os_done");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "os_done2");

        // Auto-reload period 3
        step(1'b1, 1'b1, 8'h03, 1'b1, 8'h03, 1'b0, 1'b1, "ar_load3");
        for (int i = 1; i <= 12; i++) begin
            if (i % 3 == 0)
                step(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1, "ar_tc");
            else
                step(1'b1, 1'b0, 8'h00, 1'b1, W'(3 - (i % 3)), 1'b0, 1'b1, "ar_cnt");
        end
        // auto_reload dropped mid-period takes effect at the next terminal count
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, "ar_off_2");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, "ar_off_1");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "ar_off_tc");

        // Enable gating, then a reload while running
        step(1'b0, 1'b1, 8'h0A, 1'b0, 8'h0A, 1'b0, 1'b1, "gate_load10");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b1, "gate_9");
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b1, "gate_hold");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0, 1'b1, "gate_8");
        step(1'b1, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0, 1'b1, "load_prio_40");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h3F, 1'b0, 1'b1, "after_40");

        // Load 0 goes straight to DONE without a pulse
        step(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "load0");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "load0_hold");

        // Full-range count, no wrap at zero
        step(1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1, "load_ff");
        for (int i = 254; i >= 1; i--)
            step(1'b1, 1'b0, 8'h00, 1'b0, W'(i), 1'b0, 1'b1, "ff_cnt");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "ff_tc");
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "ff_nowrap");

        // Reload value 1: a pulse on every enabled clock
        step(1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1, "r1_load");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, "r1_tc");
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, "r1_gated");
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, "r1_tc_again");
`else
        // PRESCALE=4: load 2 reaches terminal count on the 8th enabled clock
        step(1'b1, 1'b1, 8'h02, 1'b0, 8'h02, 1'b0, 1'b1, "ps_load2");
        for (int i = 1; i <= 8; i++) begin
            if (i < 4)
                step(1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, "ps_hold2");
            else if (i < 8)
                step(1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, "ps_hold1");
            else
                step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, "ps_tc");
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "ps_done");
        step(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "ps_load0");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
